fifo_pop_axis: RTL

- Read-side adapter that drains a synchronous FIFO pop port (1-cycle pop-to-data latency, `pop` ignored while `empty`) and presents an AXI4-Stream master.
- A small elastic buffer absorbs the pop latency, so throughput reaches 1 beat/cycle with no combinational path from `m_axis_tready` to `fifo_pop`.
- `m_axis_tlast` is generated from a programmable packet length.
- Sits between the stream FIFOs and the DMA/stream fabric.

---
 rtl/fifo_pop_axis_pkg.sv | 14 +
 rtl/fifo_pop_buf.sv | 54 +++++
 rtl/fifo_pop_axis.sv | 75 +++++++
 3 files changed

// File: rtl/fifo_pop_axis_pkg.sv
// Shared constants for the FIFO-pop to AXI4-Stream adapter.
package fifo_pop_axis_pkg;

  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned BUF_PTR_W = 2;
  localparam int unsigned OCC_W     = 3;
  localparam int unsigned STATS_W   = 32;

  // True when one more pop can be absorbed, counting the word still in flight.
  function automatic logic buf_has_room(input logic [OCC_W-1:0] occ, input logic infl);
    return (occ + OCC_W'(infl)) < OCC_W'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_pop_buf.sv
// Four-entry elastic ring that absorbs the one-cycle FIFO pop-to-data latency.
module fifo_pop_buf
  import fifo_pop_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  accept,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [OCC_W-1:0]      occ,
  output logic                  infl
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [BUF_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  infl_q;

  // The word popped last cycle is captured now, so infl_q doubles as the write strobe.
  always_comb occ_d = occ_q + OCC_W'(infl_q) - OCC_W'(accept);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= 1'b0;
    end else begin
      infl_q <= pop;
      if (infl_q) wr_ptr_q <= wr_ptr_q + BUF_PTR_W'(1);
      if (accept) rd_ptr_q <= rd_ptr_q + BUF_PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (infl_q) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign occ     = occ_q;
  assign infl    = infl_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(infl_q && !accept && occ_q == OCC_W'(BUF_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(accept && occ_q == '0));
`endif

endmodule

// File: rtl/fifo_pop_axis.sv
// Drains a synchronous FIFO pop port into an AXI4-Stream master with tlast packetisation.
// Define FIFO_POP_AXIS_STATS_EN to add the pkt_count and stall outputs.
module fifo_pop_axis
  import fifo_pop_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_pop_data,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
`ifdef FIFO_POP_AXIS_STATS_EN
  output logic [STATS_W-1:0]    pkt_count,
  output logic                  stall,
`endif
  output logic                  m_axis_tlast
);

  logic [OCC_W-1:0]     occ;
  logic                 infl;
  logic                 accept;
  logic [LEN_WIDTH-1:0] len_q, beat_cnt_q;

  // Room check uses registered state only, so tready never reaches fifo_pop.
  assign fifo_pop      = rst & ~fifo_empty & buf_has_room(occ, infl);
  assign m_axis_tvalid = (occ != '0);
  assign accept        = m_axis_tvalid & m_axis_tready;
  assign m_axis_tlast  = (len_q != '0) & m_axis_tvalid & (beat_cnt_q == len_q - LEN_WIDTH'(1));

  fifo_pop_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .pop    (fifo_pop),
    .wr_data(fifo_pop_data),
    .accept (accept),
    .rd_data(m_axis_tdata),
    .occ    (occ),
    .infl   (infl)
  );

  // Length is frozen once the first beat of a packet is presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      if ((beat_cnt_q == '0 && !m_axis_tvalid) || (accept && m_axis_tlast)) len_q <= cfg_len;
      if (accept) begin
        if (m_axis_tlast) beat_cnt_q <= '0;
        else if (len_q != '0) beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
      end
    end
  end

`ifdef FIFO_POP_AXIS_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count <= '0;
      stall     <= 1'b0;
    end else begin
      if (accept && m_axis_tlast) pkt_count <= pkt_count + STATS_W'(1);
      stall <= m_axis_tvalid & ~m_axis_tready;
    end
  end
`endif

endmodule
